// File: rtl/ram_frame_reader.sv
// rtl/ram_frame_reader.sv - streams one WIDTHxHEIGHT frame from the frame RAM onto a pixel stream
// Optional pixel checksum output: define READER_CHECKSUM_EN.
module ram_frame_reader #(
   parameter int WIDTH  = 160,
   parameter int HEIGHT = 120,
   parameter int ADDR_W = 19,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] ram_rdaddr,
   output logic              ram_rden,
   input  logic [DATA_W-1:0] ram_q,
   output logic [DATA_W-1:0] pix_data,
   output logic              pix_valid,
   input  logic              pix_ready,
   output logic [7:0]        pix_x,
   output logic [6:0]        pix_y,
   output logic              pix_sof,
   output logic              pix_eol,
   output logic              pix_last
`ifdef READER_CHECKSUM_EN
   ,
   output logic [15:0]       checksum
`endif
);

   localparam int TOTAL = WIDTH * HEIGHT;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t            state, next_state;
   logic [1:0]        count;
   logic [1:0]        occ;
   logic              inflight;
   logic              wr_ptr, rd_ptr;
   logic [DATA_W-1:0] buf0, buf1;
   logic              pop, start_acc, last_addr;

   assign pop       = pix_valid & pix_ready;
   assign start_acc = (state == IDLE) & start;
   assign last_addr = (ram_rdaddr == ADDR_W'(TOTAL - 1));
   // Slots committed after this cycle: buffered + in flight - popped; never exceeds 2.
   assign occ       = count + {1'b0, inflight} - {1'b0, pop};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (start) next_state = RUN;
         RUN:     if (ram_rden && last_addr) next_state = DRAIN;
         DRAIN:   if (pop && pix_last) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      busy     = (state != IDLE);
      ram_rden = (state == RUN) && !occ[1];
   end

   assign pix_valid = (count != 2'd0);
   assign pix_data  = rd_ptr ? buf1 : buf0;
   assign pix_sof   = pix_valid && (pix_x == 8'd0) && (pix_y == 7'd0);
   assign pix_eol   = pix_valid && (pix_x == 8'(WIDTH - 1));
   assign pix_last  = pix_eol && (pix_y == 7'(HEIGHT - 1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         done       <= 1'b0;
         ram_rdaddr <= '0;
         inflight   <= 1'b0;
         count      <= 2'd0;
         wr_ptr     <= 1'b0;
         rd_ptr     <= 1'b0;
         buf0       <= '0;
         buf1       <= '0;
         pix_x      <= 8'd0;
         pix_y      <= 7'd0;
      end else begin
         done <= (state == DRAIN) && pop && pix_last;
         if (start_acc) begin
            ram_rdaddr <= '0;
            inflight   <= 1'b0;
            count      <= 2'd0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            pix_x      <= 8'd0;
            pix_y      <= 7'd0;
         end else begin
            inflight <= ram_rden;
            count    <= occ;
            if (ram_rden && !last_addr)
               ram_rdaddr <= ram_rdaddr + 1'b1;
            if (inflight) begin
               if (wr_ptr) buf1 <= ram_q;
               else        buf0 <= ram_q;
               wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
               rd_ptr <= ~rd_ptr;
               if (pix_eol) begin
                  pix_x <= 8'd0;
                  pix_y <= pix_last ? 7'd0 : pix_y + 7'd1;
               end else begin
                  pix_x <= pix_x + 8'd1;
               end
            end
         end
      end
   end

`ifdef READER_CHECKSUM_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)         checksum <= 16'd0;
      else if (start_acc) checksum <= 16'd0;
      else if (pop)       checksum <= checksum + 16'(pix_data);
   end
`endif

endmodule

// File: tb/tb_ram_frame_reader.sv
// tb/tb_ram_frame_reader.sv - directed self-checking bench for ram_frame_reader
// Checksum checks are active when READER_CHECKSUM_EN is defined.
module tb_ram_frame_reader;

   localparam int TOTAL = 19200;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic        pix_ready = 1'b1;
   logic [7:0]  ram_q = 8'd0;
   logic        busy, done, ram_rden, pix_valid, pix_sof, pix_eol, pix_last;
   logic [18:0] ram_rdaddr;
   logic [7:0]  pix_data, pix_x;
   logic [6:0]  pix_y;
`ifdef READER_CHECKSUM_EN
   logic [15:0] checksum;
`endif

   int checks = 0;
   int failures = 0;
   int ram_mode = 0;
   int ready_mode = 0;
   int exp_k = 0, exp_addr = 0, issued = 0, popped = 0;
   int hs_cnt = 0, eol_cnt = 0, sof_cnt = 0;
   int cyc = 0;
   int pend = 0;
   bit mon_en = 1'b0, prev_stall = 1'b0, prev_last_hs = 1'b0, prev_done = 1'b0, pop_now = 1'b0;
   logic [26:0] prev_vec = '0, cur_vec, exp_vec;

   ram_frame_reader dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .busy       (busy),
      .done       (done),
      .ram_rdaddr (ram_rdaddr),
      .ram_rden   (ram_rden),
      .ram_q      (ram_q),
      .pix_data   (pix_data),
      .pix_valid  (pix_valid),
      .pix_ready  (pix_ready),
      .pix_x      (pix_x),
      .pix_y      (pix_y),
      .pix_sof    (pix_sof),
      .pix_eol    (pix_eol),
      .pix_last   (pix_last)
`ifdef READER_CHECKSUM_EN
      ,
      .checksum   (checksum)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk)
      if (ram_rden) ram_q <= (ram_mode == 1) ? 8'hFF : ram_rdaddr[7:0];

   initial begin
      forever begin
         @(posedge clk);
         #1;
         pix_ready = (ready_mode == 0) ? 1'b1 :
                     (ready_mode == 1) ? 1'($urandom % 2) : 1'b0;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [7:0] exp_pix(input int k);
      logic [31:0] kk;
      kk = k;
      return (ram_mode == 1) ? 8'hFF : kk[7:0];
   endfunction

   task automatic check_zero(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_rden"}, ram_rden, 0);
      chk({tag, "_addr"}, ram_rdaddr, 0);
      chk({tag, "_valid"}, pix_valid, 0);
      chk({tag, "_data"}, pix_data, 0);
      chk({tag, "_xy"}, {pix_x, pix_y}, 0);
      chk({tag, "_markers"}, {pix_sof, pix_eol, pix_last}, 0);
`ifdef READER_CHECKSUM_EN
      chk({tag, "_checksum"}, checksum, 0);
`endif
   endtask

   task automatic wait_done(input int bound, output int n);
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (!done && n < bound);
      chk("done_seen", done, 1);
   endtask

   // Reference stream model: pixel k sits at (k mod 160, k div 160).
   always @(negedge clk) begin
      if (reset && mon_en) begin
         pop_now = pix_valid && pix_ready;
         pend    = issued - popped;
         cur_vec = {pix_valid, pix_data, pix_x, pix_y, pix_sof, pix_eol, pix_last};
         if (ram_rden) begin
            chk("rd_addr", ram_rdaddr, exp_addr);
            chk("rd_room", (pend - int'(pop_now)) < 2, 1);
            exp_addr = (exp_addr == TOTAL - 1) ? 0 : exp_addr + 1;
            issued++;
         end
         if (prev_stall)
            chk("stall_hold", cur_vec, prev_vec);
         if (done) begin
            chk("done_after_last", prev_last_hs, 1);
            chk("done_single", prev_done, 0);
         end
         if (pop_now) begin
            exp_vec = {1'b1, exp_pix(exp_k), 8'(exp_k % 160), 7'(exp_k / 160),
                       exp_k == 0, (exp_k % 160) == 159, exp_k == TOTAL - 1};
            chk("pixel", cur_vec, exp_vec);
            hs_cnt++;
            if (pix_eol) eol_cnt++;
            if (pix_sof) sof_cnt++;
            exp_k = (exp_k == TOTAL - 1) ? 0 : exp_k + 1;
            popped++;
         end
         prev_last_hs = pop_now && pix_last;
         prev_done    = done;
         prev_stall   = pix_valid && !pix_ready;
         prev_vec     = cur_vec;
      end
   end

   initial begin
      #12;
      check_zero("reset");
      #6 reset = 1'b1;
      @(posedge clk);
      #1;
      chk("idle_busy", busy, 0);
      chk("idle_rden", ram_rden, 0);
      mon_en = 1'b1;

      // Frame 1: full rate, start held so frame 2 follows immediately.
      ram_mode   = 0;
      ready_mode = 0;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      chk("start_busy", busy, 1);
      chk("start_rden", ram_rden, 1);
      chk("start_addr", ram_rdaddr, 0);
      chk("lat0_valid", pix_valid, 0);
      @(posedge clk);
      #1;
      chk("lat1_valid", pix_valid, 0);
      @(posedge clk);
      #1;
      chk("lat2_valid", pix_valid, 1);
      chk("first_data", pix_data, 8'h00);
      chk("first_sof", pix_sof, 1);
      wait_done(25000, cyc);
      chk("frame_cycles", cyc + 2, 19202);
      chk("done_busy", busy, 0);
      chk("f1_pixels", hs_cnt, TOTAL);
      chk("f1_eol", eol_cnt, 120);
      chk("f1_sof", sof_cnt, 1);
`ifdef READER_CHECKSUM_EN
      chk("f1_checksum", checksum, 16'h5A80);
`endif
      hs_cnt = 0; eol_cnt = 0; sof_cnt = 0;
      ready_mode = 1;
      @(posedge clk);
      #1;
      chk("restart_busy", busy, 1);
      chk("restart_done", done, 0);
      start = 1'b0;

      // Frame 2: random ready, ignored start pulses, reset at pixel 5000.
      repeat (200) @(posedge clk);
      @(negedge clk);
      start = 1'b1;
      repeat (3) @(negedge clk);
      start = 1'b0;
      cyc = 0;
      while (hs_cnt < 5000 && cyc < 30000) begin
         @(posedge clk);
         cyc++;
      end
      chk("reach_5000", hs_cnt >= 5000, 1);
      #2 reset = 1'b0;
      #1;
      check_zero("async_reset");
      exp_k = 0; exp_addr = 0; issued = 0; popped = 0;
      hs_cnt = 0; eol_cnt = 0; sof_cnt = 0;
      prev_stall = 1'b0; prev_last_hs = 1'b0; prev_done = 1'b0;
      repeat (2) @(negedge clk);
      #2 reset = 1'b1;

      // Frame 3: all-0xFF RAM, consumer stalled 100 cycles after start.
      ram_mode   = 1;
      ready_mode = 2;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (100) @(posedge clk);
      #1;
      chk("stall_reads", issued, 2);
      chk("stall_rden", ram_rden, 0);
      chk("stall_valid", pix_valid, 1);
      chk("stall_data", pix_data, 8'hFF);
      chk("stall_sof", pix_sof, 1);
      ready_mode = 0;
      wait_done(25000, cyc);
      chk("f3_pixels", hs_cnt, TOTAL);
      chk("f3_eol", eol_cnt, 120);
      chk("f3_sof", sof_cnt, 1);
`ifdef READER_CHECKSUM_EN
      chk("f3_checksum", checksum, 16'hB500);
`endif
      @(posedge clk);
      #1;
      chk("post_done", done, 0);
      chk("post_busy", busy, 0);
`ifdef READER_CHECKSUM_EN
      chk("checksum_hold", checksum, 16'hB500);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
